// File: rtl/traffic_light_n_if.sv
// traffic_light_n_if: request/flash inputs and lamp/status outputs of the N-direction controller
interface traffic_light_n_if #(
    parameter int N_DIR = 4,
    parameter int AW = N_DIR > 2 ? $clog2(N_DIR) : 1
);
    logic [N_DIR-1:0]   req;
    logic               flash;
    logic [2*N_DIR-1:0] lights;
    logic [AW-1:0]      active;
    logic [1:0]         state;
    modport master(output req, flash, input lights, active, state);
    modport slave(input req, flash, output lights, active, state);
endinterface

// File: rtl/traffic_light_n.sv
// traffic_light_n: round-robin N-direction traffic-light controller with optional request skipping and flash mode
module traffic_light_n #(
    parameter int N_DIR    = 4,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int FLASH_T  = 4,
    parameter int CNT_W    = 8,
    parameter int SKIP_EN  = 0
) (
    input logic clk,
    input logic clear_n,
    traffic_light_n_if.slave bus
);
    localparam int AW   = N_DIR > 2 ? $clog2(N_DIR) : 1;
    localparam int GY   = GREEN_T > YELLOW_T ? GREEN_T : YELLOW_T;
    localparam int AF   = ALLRED_T > FLASH_T ? ALLRED_T : FLASH_T;
    localparam int MAXD = GY > AF ? GY : AF;
    if ((MAXD >> CNT_W) != 0) begin : g_cnt_too_narrow
        $error("CNT_W too small for the longest phase duration");
    end
    typedef enum logic [1:0] {ALLRED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10, FLASH = 2'b11} state_t;
    localparam logic [2*N_DIR-1:0] ALL_YEL = {N_DIR{2'b01}};
    state_t             st;
    logic [CNT_W-1:0]   cnt;
    logic [AW-1:0]      act, nxt;
    logic [2*N_DIR-1:0] lamps;
    logic               on;
    function automatic logic [2*N_DIR-1:0] lamp(input logic [AW-1:0] i, input logic [1:0] c);
        return (2*N_DIR)'(c) << (2*i);
    endfunction
    // descending search so the nearest requesting index after act wins
    always_comb begin
        nxt = AW'((int'(act) + 1) % N_DIR);
        if (SKIP_EN != 0)
            for (int k = N_DIR; k >= 1; k--)
                if (bus.req[(int'(act) + k) % N_DIR]) nxt = AW'((int'(act) + k) % N_DIR);
    end
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            st    <= ALLRED;
            cnt   <= CNT_W'(ALLRED_T - 1);
            act   <= AW'(N_DIR - 1);
            lamps <= '0;
            on    <= 1'b0;
        end else begin
            case (st)
                GREEN:
                    if (bus.flash || cnt == '0) begin
                        st    <= YELLOW;
                        cnt   <= CNT_W'(YELLOW_T - 1);
                        lamps <= lamp(act, 2'b01);
                    end else cnt <= cnt - CNT_W'(1);
                YELLOW:
                    if (cnt == '0) begin
                        st    <= ALLRED;
                        cnt   <= CNT_W'(ALLRED_T - 1);
                        lamps <= '0;
                    end else cnt <= cnt - CNT_W'(1);
                FLASH:
                    if (!bus.flash) begin
                        st    <= ALLRED;
                        cnt   <= CNT_W'(ALLRED_T - 1);
                        lamps <= '0;
                    end else if (cnt == '0) begin
                        on    <= !on;
                        cnt   <= CNT_W'(FLASH_T - 1);
                        lamps <= on ? '0 : ALL_YEL;
                    end else cnt <= cnt - CNT_W'(1);
                default:
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    else if (bus.flash) begin
                        st    <= FLASH;
                        cnt   <= CNT_W'(FLASH_T - 1);
                        on    <= 1'b1;
                        lamps <= ALL_YEL;
                    end else begin
                        st    <= GREEN;
                        act   <= nxt;
                        cnt   <= CNT_W'(GREEN_T - 1);
                        lamps <= lamp(nxt, 2'b10);
                    end
            endcase
        end
    end
    assign bus.lights = lamps;
    assign bus.active = act;
    assign bus.state  = st;
endmodule

// File: tb/tb_traffic_light_n.sv
// tb_traffic_light_n: scoreboard bench for traffic_light_n (default, skip-enabled and 6-direction fast instances)
module tb_traffic_light_n;
    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic [3:0] req = '0;
    logic       flash = 1'b0;
    int         total = 0;
    int         bad = 0;
    always #5 clk = ~clk;
    traffic_light_n_if b0();
    traffic_light_n_if b1();
    traffic_light_n_if #(.N_DIR(6)) b2();
    assign b0.req = req;
    assign b0.flash = flash;
    assign b1.req = req;
    assign b1.flash = flash;
    assign b2.req = '0;
    assign b2.flash = 1'b0;
    traffic_light_n u0 (.clk(clk), .clear_n(clear_n), .bus(b0));
    traffic_light_n #(.SKIP_EN(1)) u1 (.clk(clk), .clear_n(clear_n), .bus(b1));
    traffic_light_n #(.N_DIR(6), .GREEN_T(1), .YELLOW_T(1), .ALLRED_T(1)) u2 (.clk(clk), .clear_n(clear_n), .bus(b2));
    // each entry: stimulus for one edge plus the outputs expected right after it
    typedef struct {
        logic        c;
        logic [3:0]  r;
        logic        f;
        logic [15:0] l;
        logic [2:0]  a;
        logic [1:0]  s;
    } exp_t;
    exp_t       q[$];
    exp_t       e;
    logic       cur_c = 1'b1;
    logic [3:0] cur_r = '0;
    logic       cur_f = 1'b0;
    function automatic logic [15:0] lamp(int d, logic [1:0] c);
        return 16'(c) << (2 * d);
    endfunction
    function automatic int nonred(logic [15:0] l);
        int n = 0;
        for (int i = 0; i < 8; i++) if (l[2*i +: 2] != 2'b00) n++;
        return n;
    endfunction
    function automatic logic [20:0] obs(int u);
        if (u == 0) return {16'(b0.lights), 3'(b0.active), b0.state};
        if (u == 1) return {16'(b1.lights), 3'(b1.active), b1.state};
        return {16'(b2.lights), 3'(b2.active), b2.state};
    endfunction
    task automatic add(logic [15:0] l, int a, logic [1:0] s, int n);
        repeat (n) q.push_back('{cur_c, cur_r, cur_f, l, 3'(a), s});
    endtask
    task automatic svc(int d, int g, int y, int r);
        add(lamp(d, 2'b10), d, 2'b01, g);
        add(lamp(d, 2'b01), d, 2'b10, y);
        add(16'h0, d, 2'b00, r);
    endtask
    task automatic rst_seq(int a);
        cur_c = 1'b0;
        add(16'h0, a, 2'b00, 1);
        cur_c = 1'b1;
    endtask
    task automatic test_reset;
        cur_r = 4'hf;
        cur_f = 1'b1;
        rst_seq(3);
        rst_seq(3);
        cur_r = '0;
        cur_f = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front();
            clear_n = e.c; req = e.r; flash = e.f;
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                total++;
                if (obs(u) !== {e.l, e.a, e.s}) begin
                    bad++;
                    $display("FAIL reset u%0d t=%0t got=%h want=%h", u, $time, obs(u), {e.l, e.a, e.s});
                end
            end
            total++;
            if (obs(2) !== {16'h0, 3'd5, 2'b00}) begin
                bad++;
                $display("FAIL reset u2 t=%0t got=%h want=%h", $time, obs(2), {16'h0, 3'd5, 2'b00});
            end
        end
    endtask
    task automatic test_rotation;
        rst_seq(3);
        add(16'h0, 3, 2'b00, 1);
        for (int d = 0; d < 4; d++) svc(d, 8, 3, 2);
        svc(0, 8, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            clear_n = e.c; req = e.r; flash = e.f;
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                total++;
                if (obs(u) !== {e.l, e.a, e.s}) begin
                    bad++;
                    $display("FAIL rotation u%0d t=%0t got=%h want=%h", u, $time, obs(u), {e.l, e.a, e.s});
                end
            end
            total++;
            if (nonred(16'(b0.lights)) > 1) begin
                bad++;
                $display("FAIL one_nonred t=%0t got=%0d want<=1", $time, nonred(16'(b0.lights)));
            end
        end
    endtask
    task automatic test_skip;
        cur_r = 4'b0100;
        rst_seq(3);
        add(16'h0, 3, 2'b00, 1);
        svc(2, 8, 3, 2);
        svc(2, 8, 3, 2);
        add(lamp(2, 2'b10), 2, 2'b01, 3);
        cur_r = 4'b1001;
        svc(2, 5, 3, 2);
        svc(3, 8, 3, 2);
        svc(0, 8, 3, 2);
        svc(3, 8, 0, 0);
        cur_r = '0;
        while (q.size() > 0) begin
            e = q.pop_front();
            clear_n = e.c; req = e.r; flash = e.f;
            @(posedge clk); #1;
            total++;
            if (obs(1) !== {e.l, e.a, e.s}) begin
                bad++;
                $display("FAIL skip t=%0t got=%h want=%h", $time, obs(1), {e.l, e.a, e.s});
            end
        end
    endtask
    task automatic test_flash;
        rst_seq(3);
        add(16'h0, 3, 2'b00, 1);
        svc(0, 8, 3, 2);
        add(lamp(1, 2'b10), 1, 2'b01, 3);
        cur_f = 1'b1;
        add(lamp(1, 2'b01), 1, 2'b10, 3);
        add(16'h0, 1, 2'b00, 2);
        add(16'h0055, 1, 2'b11, 4);
        add(16'h0, 1, 2'b11, 4);
        add(16'h0055, 1, 2'b11, 4);
        add(16'h0, 1, 2'b11, 2);
        cur_f = 1'b0;
        add(16'h0, 1, 2'b00, 2);
        svc(2, 8, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            clear_n = e.c; req = e.r; flash = e.f;
            @(posedge clk); #1;
            total++;
            if (obs(0) !== {e.l, e.a, e.s}) begin
                bad++;
                $display("FAIL flash t=%0t got=%h want=%h", $time, obs(0), {e.l, e.a, e.s});
            end
        end
    endtask
    task automatic test_reset_mid;
        rst_seq(3);
        add(16'h0, 3, 2'b00, 1);
        for (int d = 0; d < 3; d++) svc(d, 8, 3, 2);
        svc(3, 8, 1, 0);
        rst_seq(3);
        add(16'h0, 3, 2'b00, 1);
        svc(0, 8, 3, 2);
        svc(1, 8, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            clear_n = e.c; req = e.r; flash = e.f;
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                total++;
                if (obs(u) !== {e.l, e.a, e.s}) begin
                    bad++;
                    $display("FAIL reset_mid u%0d t=%0t got=%h want=%h", u, $time, obs(u), {e.l, e.a, e.s});
                end
            end
        end
    endtask
    task automatic test_six_dir;
        rst_seq(5);
        for (int d = 0; d < 6; d++) svc(d, 1, 1, 1);
        svc(0, 1, 1, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            clear_n = e.c; req = e.r; flash = e.f;
            @(posedge clk); #1;
            total++;
            if (obs(2) !== {e.l, e.a, e.s}) begin
                bad++;
                $display("FAIL six_dir t=%0t got=%h want=%h", $time, obs(2), {e.l, e.a, e.s});
            end
        end
    endtask
    initial begin
        test_reset;
        test_rotation;
        test_skip;
        test_flash;
        test_reset_mid;
        test_six_dir;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
